// File: rtl/pcie_ss_axis_tlp_arb.sv
// Packet-atomic round-robin merge of NUM_PORTS AXI-Stream TLP requesters into
// one stream, with a single output register stage and a completed-packet counter.
module pcie_ss_axis_tlp_arb #(
  parameter  int DATA_WIDTH = 512,
  parameter  int NUM_PORTS  = 2,
  parameter  int USER_W     = 1,
  localparam int GW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_PORTS-1:0]                   in_tvalid,
  output logic [NUM_PORTS-1:0]                   in_tready,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   in_tdata,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] in_tkeep,
  input  logic [NUM_PORTS-1:0]                   in_tlast,
  input  logic [NUM_PORTS-1:0][USER_W-1:0]       in_tuser_vendor,
  output logic                                   out_tvalid,
  output logic [DATA_WIDTH-1:0]                  out_tdata,
  output logic [DATA_WIDTH/8-1:0]                out_tkeep,
  output logic                                   out_tlast,
  output logic [USER_W-1:0]                      out_tuser_vendor,
  input  logic                                   out_tready,
  output logic [31:0]                            pkt_count,
  output logic [GW-1:0]                          cur_grant
);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           last_grant_q, last_grant_d;
  logic                    out_tvalid_q, out_tvalid_d;
  logic [31:0]             pkt_count_q, pkt_count_d;
  logic [DATA_WIDTH-1:0]   out_tdata_q;
  logic [DATA_WIDTH/8-1:0] out_tkeep_q;
  logic                    out_tlast_q;
  logic [USER_W-1:0]       out_tuser_q;

  logic                    can_load;
  logic                    win_found;
  logic [GW-1:0]           win_idx;
  logic [GW-1:0]           sel_idx;
  logic                    sel_ok;
  logic                    accept;

  // Round-robin search starting just after the last granted port; iterating
  // downward lets the nearest candidate overwrite farther ones.
  always_comb begin
    logic [GW-1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = GW'((int'(last_grant_q) + k) % NUM_PORTS);
      if (in_tvalid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    can_load  = !out_tvalid_q || out_tready;
    sel_idx   = (state_q == LOCKED) ? last_grant_q : win_idx;
    sel_ok    = (state_q == LOCKED) || win_found;
    in_tready = '0;
    if (sel_ok && can_load && !rst) in_tready[sel_idx] = 1'b1;
    accept    = in_tvalid[sel_idx] && in_tready[sel_idx];
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    out_tvalid_d = out_tvalid_q;
    pkt_count_d  = pkt_count_q + 32'(out_tvalid_q && out_tready && out_tlast_q);
    if (accept) out_tvalid_d = 1'b1;
    else if (out_tready) out_tvalid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = sel_idx;
          if (!in_tlast[sel_idx]) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (accept && in_tlast[sel_idx]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GW'(NUM_PORTS - 1);
      out_tvalid_q <= 1'b0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      out_tvalid_q <= out_tvalid_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  // Payload is only meaningful alongside out_tvalid, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      out_tdata_q <= in_tdata[sel_idx];
      out_tkeep_q <= in_tkeep[sel_idx];
      out_tlast_q <= in_tlast[sel_idx];
      out_tuser_q <= in_tuser_vendor[sel_idx];
    end
  end

  assign out_tvalid       = out_tvalid_q;
  assign out_tdata        = out_tdata_q;
  assign out_tkeep        = out_tkeep_q;
  assign out_tlast        = out_tlast_q;
  assign out_tuser_vendor = out_tuser_q;
  assign pkt_count        = pkt_count_q;
  assign cur_grant        = last_grant_q;

endmodule
